// File: rtl/ddr_train_pkg.sv
// Shared types for the DDR read-eye training controller: FSM state encoding
// and the default tap type.
package ddr_train_pkg;

  localparam int DEF_MAX_TAPS = 128;
  localparam int DEF_TAP_W    = $clog2(DEF_MAX_TAPS);

  typedef logic [DEF_TAP_W-1:0] tap_t;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLEAR,
    SETTLE,
    SAMPLE,
    EVAL,
    STEP,
    CHECK,
    CENTER,
    LOAD_FAIL,
    NEXT,
    FINISH
  } state_t;

endpackage

// File: rtl/ddr_eye_sampler.sv
// Settle-then-sample timer for one tap: waits SETTLE_CYC cycles, then ORs the
// eye-monitor error flag over SAMPLE_CYC cycles and pulses done.
module ddr_eye_sampler
  import ddr_train_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flag,
  output logic sampling,
  output logic done,
  output logic err
);

  localparam int MAX_CYC = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic             active;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      sampling <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        sampling <= 1'b0;
        err      <= 1'b0;
        cnt      <= '0;
      end else if (active) begin
        if (!sampling) begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            cnt      <= '0;
            sampling <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          err <= err | flag;
          if (cnt == CNT_W'(SAMPLE_CYC - 1)) begin
            active   <= 1'b0;
            sampling <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ddr_dqs_eye_train.sv
// Read-eye centering controller: sweeps each lane's delay line upward, finds
// the passing window and parks the line at its centre, one lane at a time.
module ddr_dqs_eye_train
  import ddr_train_pkg::*;
#(
  parameter int NUM_LANES  = 9,
  parameter int MAX_TAPS   = 128,
  parameter int TAP_W      = $clog2(MAX_TAPS),
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 16,
  parameter int MIN_WIN    = 4
) (
  input  logic                       FAB_CLK,
  input  logic                       SYNC_RST,
  input  logic                       START,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [NUM_LANES-1:0]       FAIL,
  output logic [NUM_LANES*TAP_W-1:0] TAP_OUT,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  state_t               state;
  logic [LANE_W-1:0]    lane;
  logic [TAP_W-1:0]     tap, win_start, win_end, down_cnt, centre;
  logic                 win_found, phase;
  logic [TAP_W:0]       win_width, win_sum;
  logic [NUM_LANES-1:0] lane_mask, next_mask;
  logic                 smp_start, smp_flag, smp_sampling, smp_done, smp_err, oor;

  assign lane_mask = NUM_LANES'(1) << lane;
  assign next_mask = lane_mask << 1;
  assign smp_flag  = |((EYE_MONITOR_EARLY | EYE_MONITOR_LATE) & lane_mask);
  assign oor       = |(DELAY_LINE_OUT_OF_RANGE & lane_mask);
  assign smp_start = (state == CLEAR);
  assign win_width = {1'b0, win_end} - {1'b0, win_start} + 1'b1;
  assign win_sum   = {1'b0, win_start} + {1'b0, win_end};
  assign centre    = TAP_W'(win_sum >> 1);

  ddr_eye_sampler #(
    .SETTLE_CYC(SETTLE_CYC),
    .SAMPLE_CYC(SAMPLE_CYC)
  ) u_sampler (
    .clk     (FAB_CLK),
    .rst     (SYNC_RST),
    .start   (smp_start),
    .flag    (smp_flag),
    .sampling(smp_sampling),
    .done    (smp_done),
    .err     (smp_err)
  );

  // Pulses are registered on entry to the state that owns them, so each is
  // high for exactly that state's cycle and the following cycle sees its effect.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state                   <= IDLE;
      lane                    <= '0;
      tap                     <= '0;
      win_start               <= '0;
      win_end                 <= '0;
      down_cnt                <= '0;
      win_found               <= 1'b0;
      phase                   <= 1'b0;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      FAIL                    <= '0;
      TAP_OUT                 <= '0;
      DELAY_LINE_LOAD         <= '0;
      DELAY_LINE_MOVE         <= '0;
      DELAY_LINE_DIRECTION    <= '0;
      EYE_MONITOR_CLEAR_FLAGS <= '0;
    end else begin
      DELAY_LINE_LOAD         <= '0;
      DELAY_LINE_MOVE         <= '0;
      DELAY_LINE_DIRECTION    <= '0;
      EYE_MONITOR_CLEAR_FLAGS <= '0;
      case (state)
        IDLE: if (START) begin
          BUSY            <= 1'b1;
          DONE            <= 1'b0;
          FAIL            <= '0;
          TAP_OUT         <= '0;
          lane            <= '0;
          DELAY_LINE_LOAD <= NUM_LANES'(1);
          state           <= LOAD;
        end
        LOAD: begin
          tap                     <= '0;
          win_found               <= 1'b0;
          EYE_MONITOR_CLEAR_FLAGS <= lane_mask;
          state                   <= CLEAR;
        end
        CLEAR:  state <= SETTLE;
        SETTLE: if (smp_sampling) state <= SAMPLE;
        SAMPLE: if (smp_done) state <= EVAL;
        EVAL: begin
          if (!smp_err) begin
            if (!win_found) begin
              win_start <= tap;
              win_found <= 1'b1;
            end
            win_end <= tap;
          end
          if ((smp_err && win_found) || tap == TAP_W'(MAX_TAPS - 1)) begin
            state <= CHECK;
          end else begin
            DELAY_LINE_MOVE      <= lane_mask;
            DELAY_LINE_DIRECTION <= lane_mask;
            phase                <= 1'b0;
            state                <= STEP;
          end
        end
        // The idle cycle lets the delay line report a refused move.
        STEP: if (!phase) begin
          tap   <= tap + 1'b1;
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (oor) begin
            tap   <= tap - 1'b1;
            state <= CHECK;
          end else begin
            EYE_MONITOR_CLEAR_FLAGS <= lane_mask;
            state                   <= CLEAR;
          end
        end
        CHECK: if (!win_found || win_width < (TAP_W+1)'(MIN_WIN)) begin
          FAIL            <= FAIL | lane_mask;
          DELAY_LINE_LOAD <= lane_mask;
          state           <= LOAD_FAIL;
        end else begin
          down_cnt <= tap - centre;
          phase    <= 1'b0;
          state    <= CENTER;
        end
        CENTER: if (phase) begin
          phase    <= 1'b0;
          down_cnt <= down_cnt - 1'b1;
          tap      <= tap - 1'b1;
        end else if (down_cnt != '0) begin
          DELAY_LINE_MOVE <= lane_mask;
          phase           <= 1'b1;
        end else begin
          TAP_OUT[int'(lane)*TAP_W +: TAP_W] <= centre;
          state                              <= NEXT;
        end
        LOAD_FAIL: begin
          TAP_OUT[int'(lane)*TAP_W +: TAP_W] <= '0;
          tap                                <= '0;
          state                              <= NEXT;
        end
        NEXT: if (lane == LANE_W'(NUM_LANES - 1)) begin
          state <= FINISH;
        end else begin
          lane            <= lane + 1'b1;
          DELAY_LINE_LOAD <= next_mask;
          state           <= LOAD;
        end
        FINISH: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_dqs_eye_train.sv
// Bench for ddr_dqs_eye_train: behavioural delay-line/eye model per lane and
// an arithmetic reference for the expected sweep, centre and pulse counts.
module tb_ddr_dqs_eye_train;

  localparam int NL = 2;
  localparam int MT = 128;
  localparam int TW = 7;
  localparam int MINW = 4;

  logic          FAB_CLK = 1'b0;
  logic          SYNC_RST;
  logic          START;
  logic          BUSY, DONE;
  logic [NL-1:0] FAIL;
  logic [NL*TW-1:0] TAP_OUT;
  logic [NL-1:0] DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
  logic [NL-1:0] DELAY_LINE_OUT_OF_RANGE;
  logic [NL-1:0] EYE_MONITOR_CLEAR_FLAGS;
  logic [NL-1:0] EYE_MONITOR_EARLY, EYE_MONITOR_LATE;

  ddr_dqs_eye_train #(
    .NUM_LANES(NL), .MAX_TAPS(MT), .TAP_W(TW),
    .SETTLE_CYC(8), .SAMPLE_CYC(16), .MIN_WIN(MINW)
  ) dut (
    .FAB_CLK                (FAB_CLK),
    .SYNC_RST               (SYNC_RST),
    .START                  (START),
    .BUSY                   (BUSY),
    .DONE                   (DONE),
    .FAIL                   (FAIL),
    .TAP_OUT                (TAP_OUT),
    .DELAY_LINE_LOAD        (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE        (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION   (DELAY_LINE_DIRECTION),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .EYE_MONITOR_EARLY      (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE       (EYE_MONITOR_LATE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  // Lane configuration (written by the stimulus only while idle)
  int win_lo [NL];
  int win_hi [NL];
  int lim    [NL];

  // Delay-line model state and pulse counters (written only by the model)
  int phys     [NL];
  bit oor_flag [NL];
  int up_cnt   [NL];
  int dn_cnt   [NL];
  int load_cnt [NL];
  int clr_cnt  [NL];

  int base_up [NL], base_dn [NL], base_load [NL], base_clr [NL];
  int checks = 0;
  int errors = 0;

  // A delay line that refuses to go past its reachable limit and flags it.
  always @(posedge FAB_CLK) begin
    for (int i = 0; i < NL; i++) begin
      if (EYE_MONITOR_CLEAR_FLAGS[i]) clr_cnt[i] <= clr_cnt[i] + 1;
      if (DELAY_LINE_LOAD[i]) begin
        phys[i]     <= 0;
        oor_flag[i] <= 1'b0;
        load_cnt[i] <= load_cnt[i] + 1;
      end else if (DELAY_LINE_MOVE[i]) begin
        if (DELAY_LINE_DIRECTION[i]) begin
          up_cnt[i] <= up_cnt[i] + 1;
          if (phys[i] >= lim[i]) oor_flag[i] <= 1'b1;
          else phys[i] <= phys[i] + 1;
        end else begin
          dn_cnt[i]   <= dn_cnt[i] + 1;
          oor_flag[i] <= 1'b0;
          if (phys[i] > 0) phys[i] <= phys[i] - 1;
        end
      end
    end
  end

  always_comb begin
    EYE_MONITOR_EARLY       = '0;
    EYE_MONITOR_LATE        = '0;
    DELAY_LINE_OUT_OF_RANGE = '0;
    for (int i = 0; i < NL; i++) begin
      if (!(phys[i] >= win_lo[i] && phys[i] <= win_hi[i])) begin
        if (phys[i] < win_lo[i]) EYE_MONITOR_EARLY[i] = 1'b1;
        else                     EYE_MONITOR_LATE[i]  = 1'b1;
      end
      DELAY_LINE_OUT_OF_RANGE[i] = oor_flag[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the rules in arithmetic form rather than cycle by cycle.
  task automatic expectLane(input int lo, input int hi, input int lm,
                            output int etap, output int efail, output int eup,
                            output int edn, output int eload, output int eclr);
    bit has_win;
    int e, stop, oorh;
    has_win = (lo <= hi) && (lo <= lm);
    if (has_win) begin
      e    = (hi < lm) ? hi : lm;
      stop = (hi < lm) ? hi + 1 : lm;
      oorh = (hi >= lm && lm < MT - 1) ? 1 : 0;
    end else begin
      e    = 0;
      stop = lm;
      oorh = (lm < MT - 1) ? 1 : 0;
    end
    eup  = stop + oorh;
    eclr = stop + 1;
    if (has_win && (e - lo + 1) >= MINW) begin
      etap = (lo + e) / 2; efail = 0; edn = stop - etap; eload = 1;
    end else begin
      etap = 0; efail = 1; edn = 0; eload = 2;
    end
  endtask

  task automatic setLane(input int i, input int lo, input int hi, input int lm);
    win_lo[i] = lo;
    win_hi[i] = hi;
    lim[i]    = lm;
  endtask

  task automatic randomLane(input int i);
    int mode;
    mode   = int'($urandom_range(0, 3));
    lim[i] = ($urandom_range(0, 1) == 0) ? MT - 1 : int'($urandom_range(20, MT - 1));
    case (mode)
      0: begin win_lo[i] = MT + 10; win_hi[i] = -1; end
      1: begin win_lo[i] = int'($urandom_range(0, 100)); win_hi[i] = win_lo[i] + int'($urandom_range(0, 27)); end
      2: begin win_lo[i] = int'($urandom_range(0, 120)); win_hi[i] = win_lo[i] + int'($urandom_range(0, 4)); end
      default: begin win_lo[i] = int'($urandom_range(60, 126)); win_hi[i] = MT - 1; end
    endcase
  endtask

  task automatic applyStimulus();
    @(negedge FAB_CLK);
    for (int i = 0; i < NL; i++) begin
      base_up[i] = up_cnt[i]; base_dn[i] = dn_cnt[i];
      base_load[i] = load_cnt[i]; base_clr[i] = clr_cnt[i];
    end
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input bit mid_start);
    int n, etap, efail, eup, edn, eload, eclr;
    applyStimulus();
    checkOutput({name, "_busy_start"}, BUSY, 1);
    checkOutput({name, "_done_cleared"}, DONE, 0);
    checkOutput({name, "_fail_cleared"}, FAIL, 0);
    checkOutput({name, "_tapout_cleared"}, TAP_OUT, 0);
    if (mid_start) begin
      repeat (100) @(negedge FAB_CLK);
      START = 1'b1;
      @(negedge FAB_CLK);
      START = 1'b0;
    end
    n = 0;
    while (!DONE && n < 20000) begin
      @(negedge FAB_CLK);
      n++;
    end
    checkOutput({name, "_done_timeout"}, DONE, 1);
    checkOutput({name, "_busy_end"}, BUSY, 0);
    for (int i = 0; i < NL; i++) begin
      expectLane(win_lo[i], win_hi[i], lim[i], etap, efail, eup, edn, eload, eclr);
      $display("[TB] %s lane%0d win=%0d..%0d lim=%0d exp_tap=%0d exp_fail=%0d",
               name, i, win_lo[i], win_hi[i], lim[i], etap, efail);
      checkOutput($sformatf("%s_l%0d_tap", name, i), TAP_OUT[i*TW +: TW], etap);
      checkOutput($sformatf("%s_l%0d_fail", name, i), FAIL[i], efail);
      checkOutput($sformatf("%s_l%0d_up", name, i), up_cnt[i] - base_up[i], eup);
      checkOutput($sformatf("%s_l%0d_down", name, i), dn_cnt[i] - base_dn[i], edn);
      checkOutput($sformatf("%s_l%0d_load", name, i), load_cnt[i] - base_load[i], eload);
      checkOutput($sformatf("%s_l%0d_clear", name, i), clr_cnt[i] - base_clr[i], eclr);
      checkOutput($sformatf("%s_l%0d_phys", name, i), phys[i], etap);
    end
    repeat (5) @(negedge FAB_CLK);
    checkOutput({name, "_done_sticky"}, DONE, 1);
  endtask

  initial begin
    int n, tot;
    SYNC_RST = 1'b1;
    START    = 1'b0;
    for (int i = 0; i < NL; i++) setLane(i, MT + 10, -1, MT - 1);
    repeat (3) @(negedge FAB_CLK);
    SYNC_RST = 1'b0;
    @(negedge FAB_CLK);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_done", DONE, 0);
    checkOutput("reset_fail", FAIL, 0);
    checkOutput("reset_tapout", TAP_OUT, 0);
    checkOutput("reset_pulses", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}, 0);

    $display("[TB] two passing lanes");
    setLane(0, 10, 30, MT - 1);
    setLane(1, 40, 47, MT - 1);
    runAndCheck("basic", 1'b0);
    checkOutput("basic_tapout_const", TAP_OUT, {7'd43, 7'd20});

    $display("[TB] no window and window reaching the top tap");
    setLane(0, MT + 10, -1, MT - 1);
    setLane(1, 100, 127, MT - 1);
    runAndCheck("edges", 1'b0);
    checkOutput("edges_tapout_const", TAP_OUT, {7'd113, 7'd0});

    $display("[TB] narrow window and out-of-range stop");
    setLane(0, 40, 42, MT - 1);
    setLane(1, 50, 60, 60);
    runAndCheck("narrow_oor", 1'b0);
    checkOutput("narrow_oor_tapout_const", TAP_OUT, {7'd55, 7'd0});

    $display("[TB] reset during lane 1 sampling");
    setLane(0, 10, 30, MT - 1);
    setLane(1, 40, 47, MT - 1);
    applyStimulus();
    n = 0;
    while (load_cnt[1] == base_load[1] && n < 5000) begin
      @(negedge FAB_CLK);
      n++;
    end
    checkOutput("abort_lane1_load_seen", load_cnt[1] - base_load[1], 1);
    repeat (15) @(negedge FAB_CLK);
    SYNC_RST = 1'b1;
    @(negedge FAB_CLK);
    SYNC_RST = 1'b0;
    checkOutput("abort_busy", BUSY, 0);
    checkOutput("abort_done", DONE, 0);
    checkOutput("abort_tapout", TAP_OUT, 0);
    checkOutput("abort_pulses", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}, 0);
    tot = up_cnt[0] + up_cnt[1] + dn_cnt[0] + dn_cnt[1] + load_cnt[0] + load_cnt[1] + clr_cnt[0] + clr_cnt[1];
    repeat (40) @(negedge FAB_CLK);
    checkOutput("abort_quiet",
                up_cnt[0] + up_cnt[1] + dn_cnt[0] + dn_cnt[1] + load_cnt[0] + load_cnt[1] + clr_cnt[0] + clr_cnt[1], tot);
    runAndCheck("restart", 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NL; i++) randomLane(i);
      runAndCheck($sformatf("rand%0d", r), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_dqs_eye_train.md
Name: ddr_dqs_eye_train

Overview:
- Parametrised read-eye centering controller for NUM_LANES DQS/DQ IOD lanes of the DDR4 PHY.
- Drives each lane's dynamic delay line (LOAD/MOVE/DIRECTION) and reads its eye monitor (EARLY/LATE/OUT_OF_RANGE).
- Sweeps taps upward, finds the passing window, then parks the delay line at the window centre.
- Lanes are trained sequentially. Sits between the PHY training sequencer and the lane IOD wrappers in the FAB_CLK domain.

Parameters:
NUM_LANES, 9, number of lanes trained
MAX_TAPS, 128, delay-line tap count; legal taps 0..MAX_TAPS-1
TAP_W, $clog2(MAX_TAPS), tap counter width
SETTLE_CYC, 8, wait cycles after any delay-line change before sampling
SAMPLE_CYC, 16, cycles the eye monitor is observed per tap
MIN_WIN, 4, minimum passing window width in taps

Ports:
FAB_CLK  in  1  fabric clock; all logic rising-edge
SYNC_RST  in  1  synchronous, active-high reset
START  in  1  one-cycle request to train all lanes
BUSY  out  1  training in progress
DONE  out  1  sticky completion flag, cleared on next accepted START
FAIL  out  NUM_LANES  per-lane failure flag, valid when DONE=1
TAP_OUT  out  NUM_LANES*TAP_W  per-lane final tap, valid when DONE=1
DELAY_LINE_LOAD  out  NUM_LANES  one-cycle pulse; resets the lane delay to tap 0
DELAY_LINE_MOVE  out  NUM_LANES  one-cycle pulse; moves the lane delay one tap
DELAY_LINE_DIRECTION  out  NUM_LANES  1=increment, 0=decrement; qualifies MOVE
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  lane delay line at its limit
EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  one-cycle pulse clearing the lane's early/late flags
EYE_MONITOR_EARLY  in  NUM_LANES  early-edge flag
EYE_MONITOR_LATE  in  NUM_LANES  late-edge flag

Behaviour:
- Reset: all outputs 0. State IDLE, lane index 0, all tap/window registers 0. SYNC_RST mid-training aborts immediately with no further pulses; delay lines keep whatever tap they reached.
- START is accepted only in IDLE; it is ignored while BUSY. BUSY=1 from the cycle after acceptance until DONE is set. Accepting START clears DONE, FAIL and TAP_OUT.
- Only the active lane's pulse bits may be 1; all other lanes' bits are 0.
- State machine, per lane:
  - LOAD (1 cyc): pulse LOAD; tap=0; win_found=0.
  - CLEAR (1 cyc): pulse CLEAR_FLAGS.
  - SETTLE: SETTLE_CYC cycles.
  - SAMPLE: SAMPLE_CYC cycles; err |= EARLY|LATE.
  - EVAL (1 cyc):
    - Pass (err=0), no window yet: start=tap, win_found=1.
    - Pass inside window: end=tap.
    - Fail with win_found=1: window closed, go to CHECK.
    - Otherwise, if tap==MAX_TAPS-1, go to CHECK; else go to STEP.
  - STEP: MOVE with DIRECTION=1, then one idle cycle; tap+1.
    - If OUT_OF_RANGE is high on the idle cycle, the new tap is discarded: tap-1 is held and the FSM goes to CHECK.
    - Otherwise the FSM goes to CLEAR.
  - CHECK:
    - If !win_found or (end-start+1)<MIN_WIN: set FAIL[lane], go to LOAD_FAIL.
    - Otherwise centre=(start+end)>>1 (floor), down_cnt=tap-centre, go to CENTER.
  - CENTER: while down_cnt!=0, pulse MOVE with DIRECTION=0 followed by one idle cycle, down_cnt-1. Then TAP_OUT[lane]=centre, go to NEXT.
  - LOAD_FAIL (1 cyc): pulse LOAD; TAP_OUT[lane]=0; go to NEXT.
  - NEXT: if lane==NUM_LANES-1, go to FINISH; else lane+1, go to LOAD.
  - FINISH (1 cyc): DONE=1, BUSY=0, go to IDLE.
- A single-tap window (start only) sets end=start. Widths are computed in TAP_W+1 bits, so no wrap.
- The tap counter never exceeds MAX_TAPS-1 and never goes below 0.

Decomposition:
- Package ddr_train_pkg: state enum (IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, CHECK, CENTER, LOAD_FAIL, NEXT, FINISH) and a tap_t typedef parametrised by TAP_W.
- One sub-module, ddr_eye_sampler: SETTLE/SAMPLE counters and error accumulation; start/done handshake with the parent.
- Lane muxing and the FSM live in the top module.

Test Plan:
1. NUM_LANES=2. Lane 0 passes taps 10..30, lane 1 passes 40..47 -> TAP_OUT={43,20}, FAIL=0. Lane 0: 31 up MOVEs, 11 down. Lane 1: 48 up, 5 down.
2. Lane never passes -> sweep to tap 127 with 127 up MOVEs, FAIL[lane]=1, second LOAD pulse, TAP_OUT=0.
3. Lane passes 100..127 -> end=127, TAP_OUT=113, 14 down MOVEs.
4. Window 40..42 with MIN_WIN=4 -> FAIL=1, LOAD reissued, TAP_OUT=0.
5. Window 50..60, OUT_OF_RANGE asserted after the move to tap 61 -> end=60, TAP_OUT=55, no further up MOVEs.
6. SYNC_RST during lane 1 SAMPLE -> all outputs 0 the next cycle. A subsequent START restarts at lane 0 with a LOAD pulse. A START while BUSY is ignored, with no change in pulse count.
